// File: rtl/pe_id_stream_gen.sv
// pe_id_stream_gen
//   Streams multicast tags for every PE of a runtime-sized array. On start
//   the layer mapping is latched and range-checked. A legal mapping produces
//   one YID beat per row and then one XID beat per PE in raster order,
//   column fastest, over a valid/ready handshake.
// Ports
//   clk, rst              clock, async active-high reset
//   start                 latch cfg_* and begin a stream (ignored while busy)
//   cfg_array_h/_w        rows/cols in use
//   cfg_kh, cfg_e         kernel height, ofmap rows per PE set
//   cfg_t_h, cfg_t_w      vertical/horizontal set replication
//   cfg_linear            FC mapping (KH treated as 1, ifmap broadcast)
//   out_valid/out_ready   beat handshake
//   out_is_x,row,col      beat kind and PE coordinate
//   filter/ifmap/ipsum/opsum_id  tags (YID beats use the low YID_W bits)
//   busy                  stream in progress
//   y_done, x_done        pulses after the last Y / last X beat is accepted
//   cfg_err               illegal mapping seen, sticky until next start
module pe_id_stream_gen #(
  parameter int ARRAY_H_MAX = 6,
  parameter int ARRAY_W_MAX = 8,
  parameter int XID_W       = 5,
  parameter int YID_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cfg_array_h,
  input  logic [3:0]       cfg_array_w,
  input  logic [1:0]       cfg_kh,
  input  logic [2:0]       cfg_e,
  input  logic [2:0]       cfg_t_h,
  input  logic [2:0]       cfg_t_w,
  input  logic             cfg_linear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_x,
  output logic [2:0]       out_row,
  output logic [3:0]       out_col,
  output logic [XID_W-1:0] filter_id,
  output logic [XID_W-1:0] ifmap_id,
  output logic [XID_W-1:0] ipsum_id,
  output logic [XID_W-1:0] opsum_id,
  output logic             busy,
  output logic             y_done,
  output logic             x_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, CHECK, YGEN, XGEN} state_t;
  state_t state;

  // latched mapping; khe is the effective kernel height (1 in LINEAR)
  logic [2:0] h, e, t_h, t_w;
  logic [3:0] w;
  logic [1:0] kh, khe;
  logic       lin;

  // sub-counters standing in for r%KH, r/KH, c%e, c/e; ib = (c/e)*(KH+e-1)
  logic [1:0] kh_c, n_kh;
  logic [2:0] th_c, ew_c, tw_c, n_th, n_ew, n_tw, n_row;
  logic [3:0] n_col;
  logic [7:0] ib, n_ib;
  logic       n_is_x;
  logic [XID_W-1:0] t_f, t_i, t_p;

  logic accept, row_last, col_last, x_last, cfg_bad, load;

  assign accept   = out_valid && out_ready;
  assign row_last = (out_row == h - 3'd1);
  assign col_last = (out_col == w - 4'd1);
  assign x_last   = row_last && col_last;

  assign cfg_bad = (h == '0) || (w == '0) || (kh == '0) || (e == '0) ||
                   (t_h == '0) || (t_w == '0) ||
                   (int'(h) > ARRAY_H_MAX) || (int'(w) > ARRAY_W_MAX) ||
                   (int'(khe) * int'(t_h) > int'(h)) ||
                   (int'(e) * int'(t_w) > int'(w)) ||
                   ((int'(khe) + int'(e) - 1) * int'(t_w) >= (1 << XID_W));

  assign load = (state == CHECK && !cfg_bad) ||
                (state == YGEN && accept) ||
                (state == XGEN && accept && !x_last);

  // next beat position and its tags; outputs are registered from these
  always_comb begin
    n_is_x = out_is_x; n_row = out_row; n_col = out_col;
    n_kh = kh_c; n_th = th_c; n_ew = ew_c; n_tw = tw_c; n_ib = ib;
    if (state == CHECK || (state == YGEN && row_last)) begin
      n_is_x = (state == YGEN);
      n_row = '0; n_col = '0; n_kh = '0; n_th = '0;
      n_ew = '0; n_tw = '0; n_ib = '0;
    end else if (state == YGEN || (state == XGEN && col_last)) begin
      n_row = out_row + 3'd1;
      n_col = '0; n_ew = '0; n_tw = '0; n_ib = '0;
      if (kh_c == khe - 2'd1) begin
        n_kh = '0;
        n_th = th_c + 3'd1;
      end else begin
        n_kh = kh_c + 2'd1;
      end
    end else begin
      n_col = out_col + 4'd1;
      if (ew_c == e - 3'd1) begin
        n_ew = '0;
        n_tw = tw_c + 3'd1;
        n_ib = ib + 8'(khe) + 8'(e) - 8'd1;
      end else begin
        n_ew = ew_c + 3'd1;
      end
    end

    t_f = '1; t_i = '1; t_p = '1;
    if (!n_is_x) begin
      if (n_th < t_h) begin
        t_f = XID_W'(YID_W'(n_row));
        t_i = XID_W'(YID_W'(n_th));   // th == r when khe is 1
        t_p = t_i;
      end else begin
        t_f = XID_W'({YID_W{1'b1}});
        t_i = t_f;
        t_p = t_f;
      end
    end else if (n_th < t_h && n_tw < t_w) begin
      t_p = XID_W'(n_col);            // ew + e*tw collapses to c
      if (lin) begin
        t_f = XID_W'(n_col);
        t_i = '0;
      end else begin
        t_f = XID_W'(n_tw);
        t_i = XID_W'(8'(n_kh) + 8'(n_ew) + n_ib);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0; cfg_err <= 1'b0; out_valid <= 1'b0;
      y_done <= 1'b0; x_done <= 1'b0;
      h <= '0; w <= '0; kh <= '0; khe <= '0; e <= '0;
      t_h <= '0; t_w <= '0; lin <= 1'b0;
    end else begin
      y_done <= 1'b0;
      x_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          h <= cfg_array_h; w <= cfg_array_w; kh <= cfg_kh;
          khe <= cfg_linear ? 2'd1 : cfg_kh;
          e <= cfg_e; t_h <= cfg_t_h; t_w <= cfg_t_w; lin <= cfg_linear;
          cfg_err <= 1'b0;
          busy <= 1'b1;
          state <= CHECK;
        end
        CHECK: if (cfg_bad) begin
          cfg_err <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          out_valid <= 1'b1;
          state <= YGEN;
        end
        YGEN: if (accept && row_last) begin
          y_done <= 1'b1;
          state <= XGEN;
        end
        XGEN: if (accept && x_last) begin
          out_valid <= 1'b0;
          x_done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_is_x <= 1'b0; out_row <= '0; out_col <= '0;
      kh_c <= '0; th_c <= '0; ew_c <= '0; tw_c <= '0; ib <= '0;
      filter_id <= '0; ifmap_id <= '0; ipsum_id <= '0; opsum_id <= '0;
    end else if (load) begin
      out_is_x <= n_is_x; out_row <= n_row; out_col <= n_col;
      kh_c <= n_kh; th_c <= n_th; ew_c <= n_ew; tw_c <= n_tw; ib <= n_ib;
      filter_id <= t_f; ifmap_id <= t_i; ipsum_id <= t_p; opsum_id <= t_p;
    end
  end

endmodule
